noc_sequencer: RTL
==================

// Module: noc_sequencer
// PURPOSE
//  Synthesizable successor to the testbench-only NoC top sequencer. Parametrised over router count and counter widths.
//  Drives one broadcast router opcode and per-router traffic/routing-table enables through: traffic init, traffic fill,
//  router init, routing-table load, then repeated LoadStaging/Phase0/Phase1 simulation cycles.
//  Adds behaviour the old sequencer lacks: reset, start, hold, RT-load skip, max-cycle timeout, and all-done termination.
// PARAMETERS
//  NUM_ROUTERS  4   routers (and traffic sources) sequenced; also the routing-table depth per router
//  RB_W         2   width of a router index = clog2(NUM_ROUTERS), min 1
//  CNT_W        8   width of per-router packet count and fill index
//  CYCLE_W      16  width of simulation cycle counter / max_cycle
//  OP_W         3   opcode width
// PORTS
//  clk            in   1                  clock, all state on rising edge
//  rst            in   1                  asynchronous, active-high reset
//  start          in   1                  1-cycle pulse, honoured only in IDLE
//  skip_rt        in   1                  sampled with start; 1 = bypass RT_LOAD
//  max_cycle      in   CYCLE_W            sampled with start; 0 = unlimited
//  traffic_cnt    in   NUM_ROUTERS*CNT_W  packets per router, [i*CNT_W +: CNT_W], sampled with start
//  rt_present     in   NUM_ROUTERS        bit i = router i has a route for dst rt_dst (combinational from table)
//  router_done    in   NUM_ROUTERS        router i idle, all buffers empty
//  traffic_empty  in   NUM_ROUTERS        traffic source i has no pending flits
//  hold           in   1                  freeze between simulation cycles
//  router_op      out  OP_W               broadcast router opcode
//  traffic_op     out  OP_W               broadcast traffic opcode
//  traffic_en     out  NUM_ROUTERS        traffic_op applies to source i
//  fill_idx       out  CNT_W              packet index being filled
//  rt_dst         out  RB_W               destination being loaded
//  rt_en          out  NUM_ROUTERS        LoadRt applies to router i
//  in_cycle       out  CYCLE_W            completed simulation cycles
//  busy, done, timeout  out  1 each       status
// BEHAVIOUR
//  Opcodes: NOP=0 Init=1 LoadRt=2 LoadStaging=3 Phase0=4 Phase1=5 Fill=6.
//  All outputs are registered, so the opcode for state S is visible the cycle after S is entered.
//  Reset (async): state IDLE; all ops NOP, enables 0, fill_idx/rt_dst/in_cycle 0, busy/done/timeout 0.
//   Reset mid-run aborts immediately; no partial op is completed.
//  IDLE: outputs NOP. On start: latch cnt/skip_rt/max_cycle, clear done/timeout/in_cycle/fill_idx, -> TR_INIT. busy=1 outside IDLE/FINISH.
//  TR_INIT (1 cyc): traffic_op=Init, traffic_en=all ones -> TR_FILL.
//  TR_FILL: traffic_en[i]=(fill_idx<cnt[i]); if any set: traffic_op=Fill, fill_idx++ next cycle;
//   else traffic_op=NOP, -> RT_INIT.
//   All cnt zero: one NOP cycle in TR_FILL. fill_idx saturates at 2^CNT_W-1 and never wraps.
//  RT_INIT (1 cyc): router_op=Init, then -> RT_LOAD with rt_dst=0, or -> STAGE if skip_rt.
//  RT_LOAD: router_op=LoadRt, rt_en=rt_present for the current rt_dst. No bit set still emits LoadRt with rt_en=0.
//   Exactly NUM_ROUTERS cycles; rt_dst increments each cycle; after rt_dst==NUM_ROUTERS-1 -> STAGE, rt_dst back to 0.
//  STAGE: if hold, router_op=NOP and stay; else router_op=LoadStaging -> PH0.
//  PH0: router_op=Phase0 -> PH1.  PH1: router_op=Phase1, in_cycle++.
//  After PH1, first matching check wins:
//   (&router_done & &traffic_empty) -> FINISH with done=1
//   (max_cycle!=0 && in_cycle+1==max_cycle) -> FINISH with timeout=1
//   otherwise -> STAGE.
//   If both done and timeout conditions hold, done takes priority and timeout=0.
//  in_cycle saturates at all-ones and is the final count in FINISH.
//  FINISH: outputs NOP, done/timeout held. start restarts as from IDLE; otherwise state holds.
//  start outside IDLE/FINISH is ignored. hold is ignored outside STAGE.
// TESTING
//  T1: rst mid-RT_LOAD -> next edge all outputs 0, state IDLE; start then replays from TR_INIT.
//  T2: 4 routers, cnt={0,1,3,2} -> Fill cycles with traffic_en 1110, 1100, 0100, then NOP; fill_idx ends at 3.
//  T3: skip_rt=0, rt_present=4'b1011 -> 4 LoadRt cycles, rt_dst 0..3, rt_en 1011 each; skip_rt=1 -> no LoadRt at all.
//  T4: max_cycle=5, done inputs low -> exactly 5 LoadStaging/Phase0/Phase1 triples, timeout=1, in_cycle=5.
//  T5: done inputs high after cycle 2 with max_cycle=3 -> done=1, timeout=0, in_cycle=3.
//  T6: hold=1 for 7 cycles in STAGE -> 7 NOP cycles, in_cycle unchanged; start pulses during run have no effect.

Source files
------------

// File: rtl/noc_sequencer.sv
// NoC top sequencer: drives broadcast router/traffic opcodes through init, fill,
//    routing-table load and repeated LoadStaging/Phase0/Phase1 simulation cycles.
// Latency: every output is a flop; the opcode for a state appears the cycle after
//    that state is entered. Backpressure: hold freezes the run in STAGE only.
// Ports:
//    clk, rst              clock, asynchronous active-high reset
//    start/skip_rt/max_cycle/traffic_cnt   run request and its settings (sampled with start)
//    rt_present            per-router route-present flags for the current rt_dst
//    router_done/traffic_empty             end-of-run detection inputs
//    hold                  stall between simulation cycles
//    router_op/traffic_op  broadcast opcodes; traffic_en/rt_en per-router enables
//    fill_idx/rt_dst       packet index being filled / destination being loaded
//    in_cycle              completed simulation cycles; busy/done/timeout status
module noc_sequencer #(
   parameter int NUM_ROUTERS = 4,
   parameter int RB_W        = 2,
   parameter int CNT_W       = 8,
   parameter int CYCLE_W     = 16,
   parameter int OP_W        = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         skip_rt,
   input  logic [CYCLE_W-1:0]           max_cycle,
   input  logic [NUM_ROUTERS*CNT_W-1:0] traffic_cnt,
   input  logic [NUM_ROUTERS-1:0]       rt_present,
   input  logic [NUM_ROUTERS-1:0]       router_done,
   input  logic [NUM_ROUTERS-1:0]       traffic_empty,
   input  logic                         hold,
   output logic [OP_W-1:0]              router_op,
   output logic [OP_W-1:0]              traffic_op,
   output logic [NUM_ROUTERS-1:0]       traffic_en,
   output logic [CNT_W-1:0]             fill_idx,
   output logic [RB_W-1:0]              rt_dst,
   output logic [NUM_ROUTERS-1:0]       rt_en,
   output logic [CYCLE_W-1:0]           in_cycle,
   output logic                         busy,
   output logic                         done,
   output logic                         timeout
);

   localparam logic [OP_W-1:0] OP_NOP     = OP_W'(0);
   localparam logic [OP_W-1:0] OP_INIT    = OP_W'(1);
   localparam logic [OP_W-1:0] OP_LOADRT  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_LOADSTG = OP_W'(3);
   localparam logic [OP_W-1:0] OP_PHASE0  = OP_W'(4);
   localparam logic [OP_W-1:0] OP_PHASE1  = OP_W'(5);
   localparam logic [OP_W-1:0] OP_FILL    = OP_W'(6);

   typedef enum logic [3:0] {
      IDLE, TR_INIT, TR_FILL, RT_INIT, RT_LOAD, STAGE, PH0, PH1, FINISH
   } state_t;

   state_t                       state, state_nxt;
   logic [NUM_ROUTERS*CNT_W-1:0] cnt_q;
   logic                         skip_q;
   logic [CYCLE_W-1:0]           max_q;
   logic                         load_cfg;
   logic [NUM_ROUTERS-1:0]       fill_en;

   logic [OP_W-1:0]              router_op_nxt, traffic_op_nxt;
   logic [NUM_ROUTERS-1:0]       traffic_en_nxt, rt_en_nxt;
   logic [CNT_W-1:0]             fill_idx_nxt;
   logic [RB_W-1:0]              rt_dst_nxt;
   logic [CYCLE_W-1:0]           in_cycle_nxt;
   logic                         done_nxt, timeout_nxt;

   // Sources still owed a packet at the current fill index.
   always_comb begin
      fill_en = '0;
      for (int i = 0; i < NUM_ROUTERS; i++)
         fill_en[i] = (fill_idx < cnt_q[i*CNT_W +: CNT_W]);
   end

   always_comb begin
      state_nxt      = state;
      router_op_nxt  = OP_NOP;
      traffic_op_nxt = OP_NOP;
      traffic_en_nxt = '0;
      rt_en_nxt      = '0;
      fill_idx_nxt   = fill_idx;
      rt_dst_nxt     = rt_dst;
      in_cycle_nxt   = in_cycle;
      done_nxt       = done;
      timeout_nxt    = timeout;
      load_cfg       = 1'b0;
      case (state)
         IDLE, FINISH: begin
            if (start) begin
               load_cfg     = 1'b1;
               done_nxt     = 1'b0;
               timeout_nxt  = 1'b0;
               in_cycle_nxt = '0;
               fill_idx_nxt = '0;
               rt_dst_nxt   = '0;
               state_nxt    = TR_INIT;
            end
         end
         TR_INIT: begin
            traffic_op_nxt = OP_INIT;
            traffic_en_nxt = '1;
            state_nxt      = TR_FILL;
         end
         TR_FILL: begin
            if (|fill_en) begin
               traffic_op_nxt = OP_FILL;
               traffic_en_nxt = fill_en;
               fill_idx_nxt   = (fill_idx == '1) ? fill_idx : fill_idx + CNT_W'(1);
            end else begin
               state_nxt = RT_INIT;
            end
         end
         RT_INIT: begin
            router_op_nxt = OP_INIT;
            rt_dst_nxt    = '0;
            state_nxt     = skip_q ? STAGE : RT_LOAD;
         end
         RT_LOAD: begin
            // rt_present is looked up from the rt_dst currently on the output.
            router_op_nxt = OP_LOADRT;
            rt_en_nxt     = rt_present;
            if (rt_dst == RB_W'(NUM_ROUTERS-1)) begin
               rt_dst_nxt = '0;
               state_nxt  = STAGE;
            end else begin
               rt_dst_nxt = rt_dst + RB_W'(1);
            end
         end
         STAGE: begin
            if (!hold) begin
               router_op_nxt = OP_LOADSTG;
               state_nxt     = PH0;
            end
         end
         PH0: begin
            router_op_nxt = OP_PHASE0;
            state_nxt     = PH1;
         end
         PH1: begin
            router_op_nxt = OP_PHASE1;
            in_cycle_nxt  = (in_cycle == '1) ? in_cycle : in_cycle + CYCLE_W'(1);
            // Natural completion outranks the cycle limit.
            if (&router_done && &traffic_empty) begin
               done_nxt  = 1'b1;
               state_nxt = FINISH;
            end else if (max_q != '0 &&
                         ({1'b0, in_cycle} + (CYCLE_W+1)'(1)) == {1'b0, max_q}) begin
               timeout_nxt = 1'b1;
               state_nxt   = FINISH;
            end else begin
               state_nxt = STAGE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt_q      <= '0;
         skip_q     <= 1'b0;
         max_q      <= '0;
         router_op  <= OP_NOP;
         traffic_op <= OP_NOP;
         traffic_en <= '0;
         rt_en      <= '0;
         fill_idx   <= '0;
         rt_dst     <= '0;
         in_cycle   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state      <= state_nxt;
         router_op  <= router_op_nxt;
         traffic_op <= traffic_op_nxt;
         traffic_en <= traffic_en_nxt;
         rt_en      <= rt_en_nxt;
         fill_idx   <= fill_idx_nxt;
         rt_dst     <= rt_dst_nxt;
         in_cycle   <= in_cycle_nxt;
         busy       <= !(state_nxt == IDLE || state_nxt == FINISH);
         done       <= done_nxt;
         timeout    <= timeout_nxt;
         if (load_cfg) begin
            cnt_q  <= traffic_cnt;
            skip_q <= skip_rt;
            max_q  <= max_cycle;
         end
      end
   end

endmodule
